rv_fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the control decoder. It holds the PC and issues word requests to instruction memory. Returned instructions are buffered in a small FIFO, tagged with their PC, and presented to decode over a valid/ready handshake. A redirect input for branches, jumps and traps reloads the PC and discards all stale in-flight and buffered instructions.

---
 rtl/rv_fetch_stage.sv | 135 +++++++++++++
 tb/tb_rv_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: PC sequencer and instruction buffer feeding decode.
// Credit-limited fetch with redirect flush and in-order response tagging.
module rv_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        err_rsp
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          err_q, err_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic        accept;
  logic        pop;
  logic        push;
  logic        drop_rsp;
  logic        spur;
  logic [31:0] target;
  logic [CW:0] used;

  assign target   = redirect_pc & ~32'h3;
  assign used     = {1'b0, cnt_q} + {1'b0, outst_q};

  assign imem_req_valid = !rst && (used < DEPTH_C);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign drop_rsp = imem_rsp_valid && (drop_q != '0);
  assign push     = imem_rsp_valid && (drop_q == '0)
                    && (outst_q != '0);
  assign spur     = imem_rsp_valid && (outst_q == '0);

  assign if_valid = (cnt_q != '0);
  assign pop      = if_valid & if_ready;
  assign if_instr = instr_mem[rd_q];
  assign if_pc    = pc_mem[rd_q];
  assign err_rsp  = err_q;

  // next-state for PC, counters and buffer pointers; redirect wins
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    cnt_d    = cnt_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    err_d    = err_q | spur;
    if (accept) begin
      pc_d    = pc_q + 32'd4;
      outst_d = outst_d + CW'(1);
    end
    if (drop_rsp || push) begin
      outst_d = outst_d - CW'(1);
    end
    if (drop_rsp) begin
      drop_d = drop_q - CW'(1);
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_d     = wr_q + PW'(1);
      cnt_d    = cnt_d + CW'(1);
    end
    if (pop) begin
      rd_d  = rd_q + PW'(1);
      cnt_d = cnt_d - CW'(1);
    end
    if (redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      cnt_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      drop_d   = outst_d;
    end
  end

  // control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC & ~32'h3;
      rsp_pc_q <= RESET_PC & ~32'h3;
      cnt_q    <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  // buffer storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !redirect_valid && !rst) begin
      instr_mem[wr_q] <= imem_rsp_data;
      pc_mem[wr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_rv_fetch_stage.sv
// tb_rv_fetch_stage: directed bench with memory model and PC scoreboard.
// Expected PCs are queued per step and popped on each decode handshake.
module tb_rv_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        err_rsp;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;
  bit spur   = 1'b0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pend [$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rv_fetch_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .err_rsp        (err_rsp)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    chk(tag, 32'(exp_q.size()), 32'd0);
    if_ready = 1'b0;
  endtask

  // memory response driver: in-order, fixed latency
  always @(posedge clk) begin : mem_rsp
    pend_t p;
    cyc = cyc + 1;
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(p.a);
    end else if (spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      spur = 1'b0;
    end
  end

  // request capture and decode-side scoreboard
  always @(negedge clk) begin : mon
    pend_t       n;
    logic [31:0] e;
    if (rst) begin
      pend.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      n.a   = imem_addr;
      n.due = cyc + lat;
      pend.push_back(n);
    end
    if (if_valid && if_ready) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, mdata(e));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    tick(2);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_err", 32'(err_rsp), 32'd0);
    chk("rst_addr", imem_addr, RPC);

    // streaming from reset
    tick(1);
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    push_seq(32'h0, 8);
    @(negedge clk);
    chk("st_first_req", 32'(imem_req_valid), 32'd1);
    chk("st_ifv_c0", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("st_ifv_c1", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("st_ifv_c2", 32'(if_valid), 32'd1);
    chk("st_first_pc", if_pc, 32'h0);
    wait_drain("st_drain");

    // decode backpressure
    reset_dut();
    imem_req_ready = 1'b1;
    push_seq(32'h0, 4);
    tick(6);
    @(negedge clk);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_if_valid", 32'(if_valid), 32'd1);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_head", if_pc, 32'h0);
    tick(1);
    if_ready = 1'b1;
    wait_drain("bp_drain");

    // redirect with two requests outstanding
    reset_dut();
    lat      = 3;
    if_ready = 1'b1;
    tick(2);
    @(negedge clk);
    chk("rd_credit", 32'(imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick(1);
    redirect_valid = 1'b0;
    push_seq(32'h100, 8);
    @(negedge clk);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_ifv", 32'(if_valid), 32'd0);
    wait_drain("rd_drain");

    // redirect with full buffer and pop in the same cycle
    reset_dut();
    lat = 1;
    exp_q.push_back(32'h0);
    tick(6);
    @(negedge clk);
    chk("ff_full_ifv", 32'(if_valid), 32'd1);
    chk("ff_full_req", 32'(imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    if_ready       = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    push_seq(32'h200, 8);
    @(negedge clk);
    chk("ff_clear_ifv", 32'(if_valid), 32'd0);
    wait_drain("ff_drain");

    // back-to-back redirects, last wins, PC wraps past 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick(1);
    redirect_pc    = 32'hFFFF_FFFA;
    tick(1);
    redirect_valid = 1'b0;
    push_seq(32'hFFFF_FFF8, 4);
    @(negedge clk);
    chk("bb_addr", imem_addr, 32'hFFFF_FFF8);
    tick(1);
    if_ready = 1'b1;
    wait_drain("bb_drain");

    // memory stall holds the address
    imem_req_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_addr, 32'h0);
    end
    tick(1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("stall_acc_addr", imem_addr, 32'h0);
    tick(1);
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("stall_adv_addr", imem_addr, 32'h4);
    exp_q.push_back(32'h0);
    tick(1);
    if_ready = 1'b1;
    wait_drain("stall_drain");

    // spurious response with nothing outstanding
    spur = 1'b1;
    tick(3);
    @(negedge clk);
    chk("sp_err", 32'(err_rsp), 32'd1);
    chk("sp_ifv", 32'(if_valid), 32'd0);
    tick(4);
    @(negedge clk);
    chk("sp_err_sticky", 32'(err_rsp), 32'd1);

    // reset pulse in the middle of fetching
    tick(1);
    imem_req_ready = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rr_ifv", 32'(if_valid), 32'd0);
    chk("rr_addr", imem_addr, RPC);
    chk("rr_err", 32'(err_rsp), 32'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
